sdram_pixel_buffer: RTL and testbench



---
 rtl/sdram_pixbuf_pkg.sv | 19 +
 rtl/pixbuf_fifo.sv | 77 +++++++
 rtl/sdram_pixel_buffer.sv | 161 ++++++++++++++++
 tb/tb_sdram_pixel_buffer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pixbuf_pkg.sv
// Shared types and default sizing for the SDRAM pixel buffer.
package sdram_pixbuf_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_SPACE,
      REQ,
      RECV,
      DRAIN,
      DONE
   } pixbuf_state_t;

   localparam int DEFAULT_DEPTH     = 64;
   localparam int DEFAULT_BURST_LEN = 8;
   localparam int DEFAULT_IMG_WORDS = 128;

endpackage

// File: rtl/pixbuf_fifo.sv
// Single-clock FIFO with a show-ahead head register, synchronous flush and occupancy output.
module pixbuf_fifo
   import sdram_pixbuf_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                   ck,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  word_t                  wr_data,
   input  logic                   pop_ready,
   output word_t                  head_data,
   output logic                   head_valid,
   output logic [$clog2(DEPTH):0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   word_t             mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  mem_count;
   logic              pop;
   logic              load_slot;
   logic              refill;
   logic              bypass;
   logic              mem_write;

   // The head register counts toward occupancy; a push into an empty FIFO bypasses the array.
   assign pop       = head_valid && pop_ready;
   assign load_slot = !head_valid || pop;
   assign refill    = load_slot && (mem_count != '0);
   assign bypass    = load_slot && (mem_count == '0) && push;
   assign mem_write = push && !bypass;
   assign level     = mem_count + {{PTR_W{1'b0}}, head_valid};

   always_ff @(posedge ck) begin
      if (mem_write && !flush)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_count  <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         mem_count  <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         if (mem_write)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (refill) begin
            head_data  <= mem[rd_ptr];
            head_valid <= 1'b1;
            rd_ptr     <= rd_ptr + PTR_W'(1);
         end else if (bypass) begin
            head_data  <= wr_data;
            head_valid <= 1'b1;
         end else if (pop) begin
            head_valid <= 1'b0;
         end
         if (mem_write && !refill)
            mem_count <= mem_count + LVL_W'(1);
         else if (!mem_write && refill)
            mem_count <= mem_count - LVL_W'(1);
      end
   end

endmodule

// File: rtl/sdram_pixel_buffer.sv
// Burst requester and frame tracker feeding the pixel FIFO from the SDRAM read path.
// Optional max_level watermark output is enabled by SDRAM_PIXBUF_WATERMARK_EN.
module sdram_pixel_buffer
   import sdram_pixbuf_pkg::*;
#(
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter int BURST_LEN = DEFAULT_BURST_LEN,
   parameter int IMG_WORDS = DEFAULT_IMG_WORDS
) (
   input  logic                   ck,
   input  logic                   reset,
   input  logic                   frame_start,
   output logic                   burst_req,
   input  logic                   burst_ack,
   input  logic [15:0]            rd_data,
   input  logic                   rd_valid,
   output logic [15:0]            pix_data,
   output logic                   pix_valid,
   input  logic                   pix_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   frame_loaded,
`ifdef SDRAM_PIXBUF_WATERMARK_EN
   output logic [$clog2(DEPTH):0] max_level,
`endif
   output logic                   err
);

   localparam int LVL_W  = $clog2(DEPTH) + 1;
   localparam int BEAT_W = $clog2(BURST_LEN) + 1;
   localparam int WRX_W  = $clog2(IMG_WORDS) + 1;

   localparam logic [LVL_W-1:0]  FULL_LEVEL  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0]  SPACE_LIMIT = LVL_W'(DEPTH - BURST_LEN);
   localparam logic [BEAT_W-1:0] BURST_BEATS = BEAT_W'(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
   localparam logic [WRX_W-1:0]  FRAME_WORDS = WRX_W'(IMG_WORDS);

   pixbuf_state_t      state;
   logic [BEAT_W-1:0]  beat_cnt;
   logic [BEAT_W-1:0]  drain_cnt;
   logic [WRX_W-1:0]   words_rx;
   logic [WRX_W-1:0]   words_rx_inc;
   logic [BEAT_W-1:0]  valid_beat;
   logic [BEAT_W-1:0]  recv_left;
   logic [BEAT_W-1:0]  drain_left;
   logic               capture;
   logic               fifo_push;
   logic               dropped;
   logic               stray;

   // A word arriving alongside frame_start belongs to the aborted burst and is counted as drained.
   assign valid_beat   = {{(BEAT_W-1){1'b0}}, rd_valid};
   assign recv_left    = BURST_BEATS - beat_cnt - valid_beat;
   assign drain_left   = drain_cnt - valid_beat;
   assign words_rx_inc = (words_rx == FRAME_WORDS) ? words_rx : words_rx + WRX_W'(1);
   assign capture      = (state == RECV) && rd_valid && !frame_start;
   assign fifo_push    = capture && (level != FULL_LEVEL);
   assign dropped      = capture && (level == FULL_LEVEL);
   assign stray        = rd_valid && (state != RECV) && (state != DRAIN);

   pixbuf_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .ck        (ck),
      .reset     (reset),
      .flush     (frame_start),
      .push      (fifo_push),
      .wr_data   (rd_data),
      .pop_ready (pix_ready),
      .head_data (pix_data),
      .head_valid(pix_valid),
      .level     (level)
   );

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         burst_req    <= 1'b0;
         frame_loaded <= 1'b0;
         err          <= 1'b0;
         beat_cnt     <= '0;
         drain_cnt    <= '0;
         words_rx     <= '0;
      end else if (frame_start) begin
         words_rx     <= '0;
         frame_loaded <= 1'b0;
         err          <= 1'b0;
         beat_cnt     <= '0;
         burst_req    <= 1'b0;
         // A burst already committed on the bus must still be swallowed; a pending drain keeps going.
         if (state == RECV && recv_left != '0) begin
            state     <= DRAIN;
            drain_cnt <= recv_left;
         end else if (state == REQ && burst_ack) begin
            state     <= DRAIN;
            drain_cnt <= BURST_BEATS;
         end else if (state == DRAIN && drain_left != '0) begin
            state     <= DRAIN;
            drain_cnt <= drain_left;
         end else begin
            state     <= WAIT_SPACE;
         end
      end else begin
         if (stray || dropped)
            err <= 1'b1;
         case (state)
            IDLE: ;
            WAIT_SPACE: begin
               if (level <= SPACE_LIMIT) begin
                  state     <= REQ;
                  burst_req <= 1'b1;
               end
            end
            REQ: begin
               if (burst_ack) begin
                  state     <= RECV;
                  burst_req <= 1'b0;
                  beat_cnt  <= '0;
               end
            end
            RECV: begin
               if (rd_valid) begin
                  words_rx <= words_rx_inc;
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     if (words_rx_inc == FRAME_WORDS) begin
                        state        <= DONE;
                        frame_loaded <= 1'b1;
                     end else begin
                        state <= WAIT_SPACE;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (rd_valid) begin
                  drain_cnt <= drain_left;
                  if (drain_left == '0)
                     state <= WAIT_SPACE;
               end
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SDRAM_PIXBUF_WATERMARK_EN
   always_ff @(posedge ck or posedge reset) begin
      if (reset)
         max_level <= '0;
      else if (frame_start)
         max_level <= '0;
      else if (level > max_level)
         max_level <= level;
   end
`endif

endmodule

// File: tb/tb_sdram_pixel_buffer.sv
// Directed self-checking bench for sdram_pixel_buffer (default build, or with SDRAM_PIXBUF_WATERMARK_EN).
module tb_sdram_pixel_buffer;

   logic        ck;
   logic        reset;
   logic        frame_start;
   logic        burst_req;
   logic        burst_ack;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [6:0]  level;
   logic        frame_loaded;
   logic        err;
`ifdef SDRAM_PIXBUF_WATERMARK_EN
   logic [6:0]  max_level;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   sdram_pixel_buffer dut (
      .ck          (ck),
      .reset       (reset),
      .frame_start (frame_start),
      .burst_req   (burst_req),
      .burst_ack   (burst_ack),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .level       (level),
      .frame_loaded(frame_loaded),
`ifdef SDRAM_PIXBUF_WATERMARK_EN
      .max_level   (max_level),
`endif
      .err         (err)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic pulse_frame_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_for_req(input int limit, output bit seen);
      int n = 0;
      seen = 1'b0;
      while (!burst_req && n < limit) begin
         tick();
         n++;
      end
      if (burst_req) seen = 1'b1;
   endtask

   task automatic ack_now();
      burst_ack = 1'b1;
      tick();
      burst_ack = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w);
      rd_data  = w;
      rd_valid = 1'b1;
      tick();
      rd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      n_checks++; if (burst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_burst_req: got %b expected 0", burst_req); end
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pix_valid: got %b expected 0", pix_valid); end
      n_checks++; if (pix_data !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_pix_data: got %h expected 0000", pix_data); end
      n_checks++; if (level !== 7'd0) begin n_fail++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
      n_checks++; if (frame_loaded !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_loaded: got %b expected 0", frame_loaded); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
      tick();
      tick();
      reset = 1'b0;
      tick();
      n_checks++; if (burst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_no_req: got %b expected 0", burst_req); end
   endtask

   task automatic test_basic_frame();
      bit seen;
      bit late_req;
      int bursts;
      logic [15:0] exp;
      bursts = 0;
      pix_ready = 1'b1;
      pulse_frame_start();
      for (int b = 0; b < 16; b++) begin
         wait_for_req(20, seen);
         n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_req[%0d]: got %b expected 1", b, seen); end
         if (seen) bursts++;
         tick();
         tick();
         ack_now();
         n_checks++; if (burst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_req_drop[%0d]: got %b expected 0", b, burst_req); end
         for (int i = 0; i < 8; i++) begin
            exp = 16'(b * 8 + i);
            send_word(exp);
            n_checks++; if (pix_valid !== 1'b1 || pix_data !== exp) begin n_fail++; $display("[TB] FAIL basic_data: got %b/%h expected 1/%h", pix_valid, pix_data, exp); end
            if (exp == 16'd64) begin
               n_checks++; if (level !== 7'd1) begin n_fail++; $display("[TB] FAIL basic_push_pop_level: got %0d expected 1", level); end
            end
            if (exp == 16'd126) begin
               n_checks++; if (frame_loaded !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_early_loaded: got %b expected 0", frame_loaded); end
            end
         end
      end
      n_checks++; if (frame_loaded !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_frame_loaded: got %b expected 1", frame_loaded); end
      late_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (burst_req) late_req = 1'b1;
      end
      n_checks++; if (bursts !== 16) begin n_fail++; $display("[TB] FAIL basic_burst_count: got %0d expected 16", bursts); end
      n_checks++; if (late_req !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_extra_req: got %b expected 0", late_req); end
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_empty: got %b expected 0", pix_valid); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_err: got %b expected 0", err); end
   endtask

   task automatic test_backpressure();
      bit seen;
      bit extra_req;
      logic [15:0] exp;
      pix_ready = 1'b0;
      pulse_frame_start();
      for (int b = 0; b < 8; b++) begin
         wait_for_req(20, seen);
         n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_req[%0d]: got %b expected 1", b, seen); end
         ack_now();
         for (int i = 0; i < 8; i++) send_word(16'(b * 8 + i));
         n_checks++; if (level !== 7'(8 * (b + 1))) begin n_fail++; $display("[TB] FAIL bp_level[%0d]: got %0d expected %0d", b, level, 8 * (b + 1)); end
      end
      extra_req = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (burst_req) extra_req = 1'b1;
      end
      n_checks++; if (extra_req !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req_when_full: got %b expected 0", extra_req); end
      n_checks++; if (pix_valid !== 1'b1 || pix_data !== 16'h0) begin n_fail++; $display("[TB] FAIL bp_head: got %b/%h expected 1/0000", pix_valid, pix_data); end
      pix_ready = 1'b1;
      for (int j = 1; j < 64; j++) begin
         tick();
         n_checks++; if (pix_valid !== 1'b1 || pix_data !== 16'(j)) begin n_fail++; $display("[TB] FAIL bp_drain: got %b/%h expected 1/%h", pix_valid, pix_data, 16'(j)); end
      end
      tick();
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_empty: got %b expected 0", pix_valid); end
      n_checks++; if (burst_req !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_resume_req: got %b expected 1", burst_req); end
      ack_now();
      for (int i = 0; i < 8; i++) begin
         exp = 16'(64 + i);
         send_word(exp);
         n_checks++; if (pix_valid !== 1'b1 || pix_data !== exp) begin n_fail++; $display("[TB] FAIL bp_resume_data: got %b/%h expected 1/%h", pix_valid, pix_data, exp); end
      end
   endtask

   task automatic test_latency();
      bit seen;
      pix_ready = 1'b0;
      pulse_frame_start();
      wait_for_req(20, seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL lat_req: got %b expected 1", seen); end
      ack_now();
      n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL lat_before: got %b expected 0", pix_valid); end
      send_word(16'hA5A5);
      n_checks++; if (pix_valid !== 1'b1 || pix_data !== 16'hA5A5) begin n_fail++; $display("[TB] FAIL lat_first: got %b/%h expected 1/a5a5", pix_valid, pix_data); end
      n_checks++; if (level !== 7'd1) begin n_fail++; $display("[TB] FAIL lat_level: got %0d expected 1", level); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (pix_valid !== 1'b1 || pix_data !== 16'hA5A5) begin n_fail++; $display("[TB] FAIL lat_hold[%0d]: got %b/%h expected 1/a5a5", i, pix_valid, pix_data); end
      end
      pix_ready = 1'b1;
      for (int i = 0; i < 7; i++) send_word(16'(16'hB000 + i));
   endtask

   task automatic test_abort();
      bit seen;
      pix_ready = 1'b0;
      pulse_frame_start();
      wait_for_req(20, seen);
      ack_now();
      for (int i = 0; i < 3; i++) send_word(16'(16'h0100 + i));
      n_checks++; if (level !== 7'd3) begin n_fail++; $display("[TB] FAIL abort_pre_level: got %0d expected 3", level); end
      pulse_frame_start();
      n_checks++; if (level !== 7'd0 || pix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flush: got level %0d valid %b expected 0/0", level, pix_valid); end
      for (int i = 0; i < 5; i++) begin
         send_word(16'(16'h0200 + i));
         n_checks++; if (level !== 7'd0 || burst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_discard[%0d]: got level %0d req %b expected 0/0", i, level, burst_req); end
      end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_err: got %b expected 0", err); end
      wait_for_req(5, seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_new_req: got %b expected 1", seen); end
      ack_now();
      for (int i = 0; i < 8; i++) send_word(16'(16'h0300 + i));
      n_checks++; if (pix_data !== 16'h0300 || level !== 7'd8) begin n_fail++; $display("[TB] FAIL abort_new_burst: got %h/%0d expected 0300/8", pix_data, level); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_err_end: got %b expected 0", err); end
   endtask

   task automatic test_start_with_ack();
      bit seen;
      pix_ready = 1'b0;
      wait_for_req(20, seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL swa_req: got %b expected 1", seen); end
      frame_start = 1'b1;
      burst_ack   = 1'b1;
      tick();
      frame_start = 1'b0;
      burst_ack   = 1'b0;
      n_checks++; if (burst_req !== 1'b0 || level !== 7'd0) begin n_fail++; $display("[TB] FAIL swa_flush: got req %b level %0d expected 0/0", burst_req, level); end
      for (int i = 0; i < 8; i++) send_word(16'(16'h0400 + i));
      n_checks++; if (level !== 7'd0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL swa_drain: got level %0d err %b expected 0/0", level, err); end
      wait_for_req(5, seen);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL swa_new_req: got %b expected 1", seen); end
      ack_now();
      send_word(16'h0500);
      n_checks++; if (pix_valid !== 1'b1 || pix_data !== 16'h0500) begin n_fail++; $display("[TB] FAIL swa_data: got %b/%h expected 1/0500", pix_valid, pix_data); end
   endtask

   task automatic test_stray();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      send_word(16'hDEAD);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL stray_err: got %b expected 1", err); end
      n_checks++; if (level !== 7'd0 || pix_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stray_level: got %0d/%b expected 0/0", level, pix_valid); end
      for (int i = 0; i < 3; i++) tick();
      n_checks++; if (err !== 1'b1 || burst_req !== 1'b0) begin n_fail++; $display("[TB] FAIL stray_sticky: got err %b req %b expected 1/0", err, burst_req); end
      pulse_frame_start();
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL stray_clear: got %b expected 0", err); end
   endtask

   task automatic test_reset_mid_recv();
      bit seen;
      pix_ready = 1'b0;
      wait_for_req(20, seen);
      ack_now();
      for (int i = 0; i < 3; i++) send_word(16'(16'h0600 + i));
      n_checks++; if (level !== 7'd3) begin n_fail++; $display("[TB] FAIL rmr_pre_level: got %0d expected 3", level); end
      reset = 1'b1;
      #1;
      n_checks++; if (burst_req !== 1'b0 || pix_valid !== 1'b0 || pix_data !== 16'h0) begin n_fail++; $display("[TB] FAIL rmr_async_out: got %b/%b/%h expected 0/0/0000", burst_req, pix_valid, pix_data); end
      n_checks++; if (level !== 7'd0 || frame_loaded !== 1'b0 || err !== 1'b0) begin n_fail++; $display("[TB] FAIL rmr_async_state: got %0d/%b/%b expected 0/0/0", level, frame_loaded, err); end
      #1;
      reset = 1'b0;
      send_word(16'h0603);
      n_checks++; if (err !== 1'b1 || level !== 7'd0) begin n_fail++; $display("[TB] FAIL rmr_late_word: got err %b level %0d expected 1/0", err, level); end
   endtask

   initial begin
      reset       = 1'b1;
      frame_start = 1'b0;
      burst_ack   = 1'b0;
      rd_data     = '0;
      rd_valid    = 1'b0;
      pix_ready   = 1'b0;
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_latency();
      test_abort();
      test_start_with_ack();
      test_stray();
      test_reset_mid_recv();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

endmodule
